// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: the 16-state encoding, instruction opcodes, DR select codes
// and the standard next-state graph.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BSR,
        DR_ID,
        DR_BYPASS
    } dr_sel_e;

    localparam int unsigned EXTEST         = 0;
    localparam int unsigned SAMPLE_PRELOAD = 1;
    localparam int unsigned IDCODE         = 2;
    localparam int unsigned USERCODE       = 3;
    localparam int unsigned ID_LEN         = 32;

    function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
        case (s)
            TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   next_state = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       next_state = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         next_state = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         next_state = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         next_state = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         next_state = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next_state = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         next_state = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         next_state = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         next_state = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         next_state = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          next_state = TEST_LOGIC_RESET;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_bscan_if.sv
// Serial JTAG pin bundle: the tester side drives tms/tdi, the TAP drives tdo/tdo_oe.
interface jtag_tap_bscan_if;

    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_oe;

    modport master (output tms, output tdi, input tdo, input tdo_oe);
    modport slave  (input tms, input tdi, output tdo, output tdo_oe);

endinterface

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register; strobes are registered from the next state so they
// are asserted for exactly the cycle the controller sits in the matching state.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tms,
    output tap_state_e o_tap_state,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir,
    output logic       o_tlr
);

    tap_state_e r_state;
    tap_state_e w_next;

    assign w_next = next_state(r_state, i_tms);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= TEST_LOGIC_RESET;
            o_capture_dr <= 1'b0;
            o_shift_dr   <= 1'b0;
            o_update_dr  <= 1'b0;
            o_capture_ir <= 1'b0;
            o_shift_ir   <= 1'b0;
            o_update_ir  <= 1'b0;
            o_tlr        <= 1'b1;
        end else begin
            r_state      <= w_next;
            o_capture_dr <= (w_next == CAPTURE_DR);
            o_shift_dr   <= (w_next == SHIFT_DR);
            o_update_dr  <= (w_next == UPDATE_DR);
            o_capture_ir <= (w_next == CAPTURE_IR);
            o_shift_ir   <= (w_next == SHIFT_IR);
            o_update_ir  <= (w_next == UPDATE_IR);
            o_tlr        <= (w_next == TEST_LOGIC_RESET);
        end
    end

    assign o_tap_state = r_state;

endmodule

// File: rtl/jtag_tap_bscan.sv
// Width-generic TAP with IR, BYPASS, IDCODE and boundary-scan register plus EXTEST muxing.
// Optional JTAG_TAP_USERCODE_EN makes opcode 3 capture USERCODE_VAL into the ID register.
module jtag_tap_bscan
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IR_LEN       = 4,
    parameter int unsigned BSR_LEN      = 8,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    jtag_tap_bscan_if.slave    jtag,
    input  logic [BSR_LEN-1:0] pad_in,
    input  logic [BSR_LEN-1:0] core_in,
    output logic [BSR_LEN-1:0] pad_out,
    output logic [BSR_LEN-1:0] core_out,
    output logic [3:0]         tap_state,
    output logic [IR_LEN-1:0]  ir_out
);

    tap_state_e w_state;
    logic w_capture_dr, w_shift_dr, w_update_dr;
    logic w_capture_ir, w_shift_ir, w_update_ir, w_tlr;

    jtag_tap_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_tms        (jtag.tms),
        .o_tap_state  (w_state),
        .o_capture_dr (w_capture_dr),
        .o_shift_dr   (w_shift_dr),
        .o_update_dr  (w_update_dr),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir),
        .o_tlr        (w_tlr)
    );

    logic [IR_LEN-1:0]  r_ir_sh;
    logic [IR_LEN-1:0]  r_ir;
    logic [ID_LEN-1:0]  r_id_sh;
    logic               r_byp;
    logic [BSR_LEN-1:0] r_bsr_sh;
    logic [BSR_LEN-1:0] r_bsr_upd;

    dr_sel_e            w_sel;
    logic [ID_LEN-1:0]  w_id_cap;
    logic               w_bsr_instr;
    logic               w_tdo;
    logic               w_tdo_oe;

    assign w_bsr_instr = (r_ir == IR_LEN'(EXTEST)) || (r_ir == IR_LEN'(SAMPLE_PRELOAD));

    // Unlisted opcodes fall through to BYPASS.
    always_comb begin
        w_sel    = DR_BYPASS;
        w_id_cap = IDCODE_VAL;
        if (w_bsr_instr) begin
            w_sel = DR_BSR;
        end else if (r_ir == IR_LEN'(IDCODE)) begin
            w_sel = DR_ID;
        end
`ifdef JTAG_TAP_USERCODE_EN
        else if (r_ir == IR_LEN'(USERCODE)) begin
            w_sel    = DR_ID;
            w_id_cap = USERCODE_VAL;
        end
`endif
    end

`ifndef JTAG_TAP_USERCODE_EN
    logic w_unused_usercode;
    assign w_unused_usercode = ^USERCODE_VAL;
`endif

    // Each strobe marks the state being left, so its action lands on the exit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_sh   <= '0;
            r_ir      <= IR_LEN'(IDCODE);
            r_id_sh   <= '0;
            r_byp     <= 1'b0;
            r_bsr_sh  <= '0;
            r_bsr_upd <= '0;
        end else begin
            if (w_tlr) begin
                r_ir <= IR_LEN'(IDCODE);
            end else if (w_update_ir) begin
                r_ir <= r_ir_sh;
            end

            if (w_capture_ir) begin
                r_ir_sh <= IR_LEN'(1);
            end else if (w_shift_ir) begin
                r_ir_sh <= IR_LEN'({jtag.tdi, r_ir_sh} >> 1);
            end

            if (w_capture_dr) begin
                case (w_sel)
                    DR_BSR:  r_bsr_sh <= pad_in;
                    DR_ID:   r_id_sh  <= w_id_cap;
                    default: r_byp    <= 1'b0;
                endcase
            end else if (w_shift_dr) begin
                case (w_sel)
                    DR_BSR:  r_bsr_sh <= BSR_LEN'({jtag.tdi, r_bsr_sh} >> 1);
                    DR_ID:   r_id_sh  <= ID_LEN'({jtag.tdi, r_id_sh} >> 1);
                    default: r_byp    <= jtag.tdi;
                endcase
            end

            if (w_update_dr && w_bsr_instr) begin
                r_bsr_upd <= r_bsr_sh;
            end
        end
    end

    always_comb begin
        w_tdo    = 1'b0;
        w_tdo_oe = 1'b0;
        if (w_shift_ir) begin
            w_tdo    = r_ir_sh[0];
            w_tdo_oe = 1'b1;
        end else if (w_shift_dr) begin
            w_tdo_oe = 1'b1;
            case (w_sel)
                DR_BSR:  w_tdo = r_bsr_sh[0];
                DR_ID:   w_tdo = r_id_sh[0];
                default: w_tdo = r_byp;
            endcase
        end
    end

    assign jtag.tdo    = w_tdo;
    assign jtag.tdo_oe = w_tdo_oe;
    assign pad_out     = (r_ir == IR_LEN'(EXTEST)) ? r_bsr_upd : core_in;
    assign core_out    = pad_in;
    assign tap_state   = w_state;
    assign ir_out      = r_ir;

endmodule
